// File: rtl/msg_source_packer.sv
// Per-source message builder: packs DIN words into length/timeout-bounded messages for the slave-FIFO master.
// GOT_FULL_MSG rises 2 cycles after a closing accept; DIN_READY drops on FIFO full, pending close or MAX_LEN.

module msg_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_vld,
  output logic [DW-1:0] rd_dat,
  output logic          full,
  output logic [AW:0]   level
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LVL);
  assign do_push = wr_vld && !full;
  assign do_pop  = rd_vld && (level != '0);
  // Show-ahead head; forced to zero while empty so the output is clean after reset.
  assign rd_dat  = (level == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module msg_source_packer #(
  parameter int DEPTH   = 512,
  parameter int AW      = 9,
  parameter int MAX_LEN = 255,
  parameter int TIMEOUT = 1000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [15:0]   DIN,
  input  logic          DIN_VALID,
  input  logic          DIN_LAST,
  output logic          DIN_READY,
  input  logic          RD_REQ,
  input  logic          MSG_SENT,
  output logic [15:0]   FIFO_Q,
  output logic          GOT_FULL_MSG,
  output logic [7:0]    MSG_LEN,
  output logic [AW:0]   FILL_LEVEL,
  output logic          ERR
);
  localparam int            IW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    MAX_LEN_L = 8'(MAX_LEN);
  // Close fires in the cycle whose idle count update would reach TIMEOUT-1.
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 2);

  typedef enum logic [1:0] {TX_IDLE, TX_READ, TX_FLUSH} tx_state_t;

  tx_state_t     tx_state;
  logic [7:0]    fill_cnt;
  logic [7:0]    rd_cnt;
  logic [IW-1:0] idle_cnt;
  logic          close_pend;
  logic          msg_sent_d;
  logic          fifo_full;
  logic          accept;
  logic          timeout_hit;
  logic          close_now;
  logic          sent_rise;
  logic          pop;

  assign DIN_READY   = RST && !fifo_full && !close_pend && (fill_cnt < MAX_LEN_L);
  assign accept      = DIN_VALID && DIN_READY;
  assign timeout_hit = !accept && !close_pend && (fill_cnt != 8'd0) && (idle_cnt == IDLE_LAST);
  assign close_now   = (accept && (DIN_LAST || (fill_cnt == MAX_LEN_L - 8'd1))) || timeout_hit;
  assign sent_rise   = MSG_SENT && !msg_sent_d;

  always_comb begin
    pop = 1'b0;
    case (tx_state)
      TX_READ:  pop = RD_REQ && (rd_cnt != MSG_LEN);
      TX_FLUSH: pop = (rd_cnt != MSG_LEN);
      default:  pop = 1'b0;
    endcase
  end

  msg_fifo #(.DW(16), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .CLK    (CLK),
    .RST    (RST),
    .wr_vld (accept),
    .wr_dat (DIN),
    .rd_vld (pop),
    .rd_dat (FIFO_Q),
    .full   (fifo_full),
    .level  (FILL_LEVEL)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state     <= TX_IDLE;
      fill_cnt     <= '0;
      rd_cnt       <= '0;
      idle_cnt     <= '0;
      close_pend   <= 1'b0;
      msg_sent_d   <= 1'b0;
      GOT_FULL_MSG <= 1'b0;
      MSG_LEN      <= '0;
      ERR          <= 1'b0;
    end else begin
      msg_sent_d <= MSG_SENT;

      if (accept) begin
        fill_cnt <= fill_cnt + 8'd1;
        idle_cnt <= '0;
      end else if ((fill_cnt == 8'd0) || close_pend) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IW'(1);
      end

      if (close_now) close_pend <= 1'b1;

      case (tx_state)
        TX_IDLE: begin
          if (RD_REQ) ERR <= 1'b1;
          // close_pend blocks accepts, so fill_cnt is frozen while it is handed over.
          if (close_pend) begin
            MSG_LEN      <= fill_cnt;
            GOT_FULL_MSG <= 1'b1;
            fill_cnt     <= '0;
            close_pend   <= 1'b0;
            rd_cnt       <= '0;
            tx_state     <= TX_READ;
          end
        end
        TX_READ: begin
          if (RD_REQ) begin
            if (rd_cnt == MSG_LEN) ERR <= 1'b1;
            else                   rd_cnt <= rd_cnt + 8'd1;
          end
          if (sent_rise) begin
            GOT_FULL_MSG <= 1'b0;
            if (rd_cnt == MSG_LEN) begin
              tx_state <= TX_IDLE;
            end else begin
              ERR      <= 1'b1;
              tx_state <= TX_FLUSH;
            end
          end
        end
        TX_FLUSH: begin
          if (RD_REQ) ERR <= 1'b1;
          if (rd_cnt != MSG_LEN) rd_cnt <= rd_cnt + 8'd1;
          if ((rd_cnt == MSG_LEN) || (rd_cnt + 8'd1 == MSG_LEN)) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msg_source_packer.sv
// Randomized and directed bench for msg_source_packer with a message-level scoreboard.
module tb_msg_source_packer;
  localparam int MAX_LEN = 255;
  localparam int TIMEOUT = 1000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] DIN = '0;
  logic        DIN_VALID = 1'b0, DIN_LAST = 1'b0, RD_REQ = 1'b0, MSG_SENT = 1'b0;
  logic        DIN_READY, GOT_FULL_MSG, ERR;
  logic [15:0] FIFO_Q;
  logic [7:0]  MSG_LEN;
  logic [9:0]  FILL_LEVEL;

  logic [15:0] s_din = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_rd = 1'b0, s_sent = 1'b0;
  logic        s_ready, s_got, s_err;
  logic [15:0] s_q;
  logic [7:0]  s_len;
  logic [3:0]  s_fill;

  msg_source_packer #(.DEPTH(512), .AW(9), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) u_dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_LAST(DIN_LAST),
    .DIN_READY(DIN_READY), .RD_REQ(RD_REQ), .MSG_SENT(MSG_SENT), .FIFO_Q(FIFO_Q),
    .GOT_FULL_MSG(GOT_FULL_MSG), .MSG_LEN(MSG_LEN), .FILL_LEVEL(FILL_LEVEL), .ERR(ERR)
  );

  msg_source_packer #(.DEPTH(8), .AW(3), .MAX_LEN(5), .TIMEOUT(20)) u_small (
    .CLK(CLK), .RST(RST), .DIN(s_din), .DIN_VALID(s_valid), .DIN_LAST(s_last),
    .DIN_READY(s_ready), .RD_REQ(s_rd), .MSG_SENT(s_sent), .FIFO_Q(s_q),
    .GOT_FULL_MSG(s_got), .MSG_LEN(s_len), .FILL_LEVEL(s_fill), .ERR(s_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard: every accepted word in order, and the lengths of closed messages.
  logic [15:0] exp_words[$];
  int          exp_lens[$];
  int          open_len = 0;
  logic        err_exp  = 1'b0;
  bit          prod_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_close();
    if (open_len > 0) exp_lens.push_back(open_len);
    open_len = 0;
  endtask

  // Called at a negedge; returns at the next negedge with the word accepted.
  task automatic push_word(input logic [15:0] d, input logic last, output int edge_no);
    int guard;
    guard = 0;
    DIN = d; DIN_LAST = last; DIN_VALID = 1'b1;
    while (!DIN_READY && guard < 3000) begin
      @(negedge CLK);
      guard++;
    end
    if (!DIN_READY) begin
      check("din_ready_wait", DIN_READY, 1);
      DIN_VALID = 1'b0;
      edge_no = -1;
      return;
    end
    edge_no = cyc + 1;
    exp_words.push_back(d);
    open_len++;
    if (last || open_len == MAX_LEN) model_close();
    @(negedge CLK);
  endtask

  task automatic din_idle();
    DIN_VALID = 1'b0;
    DIN_LAST  = 1'b0;
  endtask

  task automatic wait_got(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      if (GOT_FULL_MSG) begin
        t = cyc;
        break;
      end
      @(negedge CLK);
    end
    if (t < 0) check("got_wait", GOT_FULL_MSG, 1);
  endtask

  // Reads n_rd words of the pending message (or all of it), then pulses MSG_SENT.
  task automatic drain_msg(input int n_rd, input bit gaps);
    int t, len, k;
    logic [15:0] w;
    wait_got(4000, t);
    if (t < 0) return;
    check("msg_pending_in_model", exp_lens.size() != 0, 1);
    if (exp_lens.size() == 0) return;
    len = exp_lens.pop_front();
    check("msg_len", MSG_LEN, len);
    k = (n_rd < len) ? n_rd : len;
    for (int i = 0; i < k; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) @(negedge CLK);
      w = exp_words.pop_front();
      check("fifo_q", FIFO_Q, w);
      RD_REQ = 1'b1;
      @(negedge CLK);
      RD_REQ = 1'b0;
    end
    for (int i = k; i < len; i++) void'(exp_words.pop_front());
    if (k < len) err_exp = 1'b1;
    MSG_SENT = 1'b1;
    @(negedge CLK);
    MSG_SENT = 1'b0;
    check("got_fall", GOT_FULL_MSG, 0);
    check("err", ERR, err_exp);
  endtask

  task automatic producer();
    int len, e;
    for (int m = 0; m < 30; m++) begin
      if ($urandom_range(0, 9) == 0) len = $urandom_range(256, 270);
      else                           len = $urandom_range(1, 12);
      for (int w = 0; w < len; w++) begin
        push_word(16'($urandom), (w == len - 1), e);
        if ($urandom_range(0, 3) == 0) begin
          din_idle();
          repeat ($urandom_range(1, 3)) @(negedge CLK);
        end
      end
    end
    din_idle();
    prod_done = 1'b1;
  endtask

  task automatic master();
    while (!prod_done || exp_lens.size() != 0) begin
      if (exp_lens.size() == 0) begin
        @(negedge CLK);
        continue;
      end
      drain_msg(1000, 1'b1);
    end
  endtask

  task automatic s_push(input logic [15:0] d);
    int guard;
    guard = 0;
    s_din = d; s_valid = 1'b1;
    while (!s_ready && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    check("s_ready_wait", s_ready, 1);
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  task automatic s_read(input logic [15:0] exp);
    check("s_fifo_q", s_q, exp);
    s_rd = 1'b1;
    @(negedge CLK);
    s_rd = 1'b0;
  endtask

  task automatic s_wait_got();
    for (int i = 0; i < 20 && !s_got; i++) @(negedge CLK);
    check("s_got", s_got, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, t;
    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_din_ready", DIN_READY, 0);
    check("rst_got", GOT_FULL_MSG, 0);
    check("rst_msg_len", MSG_LEN, 0);
    check("rst_fill", FILL_LEVEL, 0);
    check("rst_err", ERR, 0);
    check("rst_fifo_q", FIFO_Q, 0);
    RST = 1'b1;
    #1;
    check("ready_after_rst", DIN_READY, 1);

    // 10-word message closed by DIN_LAST
    for (int i = 1; i <= 10; i++) push_word(16'(i), (i == 10), e);
    din_idle();
    wait_got(20, t);
    check("last_to_got_edges", t, e + 1);
    check("fill_10", FILL_LEVEL, 10);
    drain_msg(10, 1'b0);
    check("fill_after_10", FILL_LEVEL, 0);

    // 300 words with no DIN_LAST: 255 by length, 45 by timeout
    for (int i = 0; i < 300; i++) begin
      push_word(16'h1000 + 16'(i), 1'b0, e);
      if (i == MAX_LEN - 1) check("ready_at_max_len", DIN_READY, 0);
    end
    din_idle();
    drain_msg(1000, 1'b0);
    model_close();
    drain_msg(1000, 1'b0);

    // No close with nothing open; 3 words close exactly TIMEOUT edges after last accept
    repeat (1100) @(negedge CLK);
    check("no_empty_close", GOT_FULL_MSG, 0);
    check("fill_idle", FILL_LEVEL, 0);
    for (int i = 0; i < 3; i++) push_word(16'hA0 + 16'(i), 1'b0, e);
    din_idle();
    wait_got(1200, t);
    check("timeout_edges", t - e, TIMEOUT);
    model_close();
    drain_msg(3, 1'b0);

    // Random traffic against the scoreboard
    fork
      producer();
      master();
    join
    repeat (3) @(negedge CLK);
    check("rand_fill_empty", FILL_LEVEL, 0);
    check("rand_err", ERR, 0);

    // Small instance: fill to DEPTH with one message pending
    for (int i = 0; i < 8; i++) s_push(16'h0A00 + 16'(i));
    check("s_fill_full", s_fill, 8);
    check("s_ready_full", s_ready, 0);
    s_wait_got();
    check("s_len_a", s_len, 5);
    s_read(16'h0A00);
    check("s_fill_after_pop", s_fill, 7);
    check("s_ready_after_pop", s_ready, 1);
    check("s_fifo_q", s_q, 16'h0A01);
    s_rd = 1'b1; s_din = 16'h0A08; s_valid = 1'b1;
    @(negedge CLK);
    s_rd = 1'b0; s_valid = 1'b0;
    check("s_fill_pop_push", s_fill, 7);
    for (int i = 2; i < 5; i++) s_read(16'h0A00 + 16'(i));
    s_sent = 1'b1;
    @(negedge CLK);
    s_sent = 1'b0;
    check("s_got_fall", s_got, 0);
    s_push(16'h0A09);
    s_wait_got();
    check("s_len_b", s_len, 5);
    for (int i = 5; i < 10; i++) s_read(16'h0A00 + 16'(i));
    s_sent = 1'b1;
    @(negedge CLK);
    s_sent = 1'b0;
    repeat (2) @(negedge CLK);
    check("s_fill_end", s_fill, 0);
    check("s_err_end", s_err, 0);

    // Early MSG_SENT: 5 of 8 read, rest flushed, next open message remains
    for (int i = 0; i < 8; i++) push_word(16'($urandom), (i == 7), e);
    for (int i = 0; i < 2; i++) push_word(16'h0B00 + 16'(i), 1'b0, e);
    din_idle();
    drain_msg(5, 1'b0);
    repeat (5) @(negedge CLK);
    check("fill_after_flush", FILL_LEVEL, 2);
    check("got_after_flush", GOT_FULL_MSG, 0);
    push_word(16'h0B02, 1'b1, e);
    din_idle();
    drain_msg(3, 1'b0);

    // Reset in the middle of a read with 4 words left
    for (int i = 0; i < 6; i++) push_word(16'h0C00 + 16'(i), (i == 5), e);
    din_idle();
    wait_got(20, t);
    check("mid_len", MSG_LEN, 6);
    for (int i = 0; i < 2; i++) begin
      check("mid_fifo_q", FIFO_Q, 16'h0C00 + 16'(i));
      RD_REQ = 1'b1;
      @(negedge CLK);
      RD_REQ = 1'b0;
    end
    RST = 1'b0;
    #1;
    check("mid_rst_got", GOT_FULL_MSG, 0);
    check("mid_rst_fill", FILL_LEVEL, 0);
    check("mid_rst_ready", DIN_READY, 0);
    check("mid_rst_err", ERR, 0);
    check("mid_rst_len", MSG_LEN, 0);
    check("mid_rst_q", FIFO_Q, 0);
    exp_words.delete();
    exp_lens.delete();
    open_len = 0;
    err_exp  = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("post_rst_ready", DIN_READY, 1);
    check("post_rst_fill", FILL_LEVEL, 0);
    @(negedge CLK);
    push_word(16'h0D00, 1'b0, e);
    push_word(16'h0D01, 1'b1, e);
    din_idle();
    drain_msg(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
